// File: rtl/sha3_selftest.sv
// BIST sequencer: drives one sha3 core through NVEC ROM vectors and scores each digest; start to first req_valid is 1+RSTCYC cycles, then at least 3 cycles per vector.
// req_valid is held until req_ready; res_ready is high only in WAIT; a watchdog aborts a hung core after TIMEOUT+1 WAIT cycles.
module sha3_selftest #(
   parameter int                    MDLEN   = 256,
   parameter int                    ILEN    = 344,
   parameter int                    NVEC    = 4,
   parameter logic [NVEC*ILEN-1:0]  VEC_MSG = '0,
   parameter logic [NVEC*MDLEN-1:0] VEC_MD  = '0,
   parameter int                    RSTCYC  = 4,
   parameter int                    TIMEOUT = 4095,
   parameter int                    CNTW    = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic             continuous,
   output logic             core_rst,
   output logic [ILEN-1:0]  md_in,
   output logic             req_valid,
   input  logic             req_ready,
   input  logic             res_valid,
   output logic             res_ready,
   input  logic [MDLEN-1:0] md_out,
   output logic             busy,
   output logic             done,
   output logic [CNTW-1:0]  pass_cnt,
   output logic [CNTW-1:0]  fail_cnt,
   output logic [CNTW-1:0]  timeout_cnt,
   output logic [3:0]       last_fail_idx,
   output logic [7:0]       led
);

   localparam int WDW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam int RCW = (RSTCYC < 2) ? 1 : $clog2(RSTCYC + 1);
   localparam logic [3:0] LAST_IDX = 4'(NVEC - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CRST,
      S_REQ,
      S_WAIT,
      S_CHECK,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [3:0]         idx_q, idx_d;
   logic [RCW-1:0]     rcnt_q, rcnt_d;
   logic [WDW-1:0]     wdog_q, wdog_d;
   logic               end_q, end_d;
   logic [MDLEN-1:0]   dig_q, dig_d;
   logic [7:0]         led_q, led_d;
   logic [CNTW-1:0]    pass_q, pass_d;
   logic [CNTW-1:0]    fail_q, fail_d;
   logic [CNTW-1:0]    tmo_q, tmo_d;
   logic [3:0]         lfi_q, lfi_d;
   logic               core_rst_q, req_valid_q, res_ready_q, busy_q, done_q;
   logic [MDLEN-1:0]   exp_md;
   logic               at_last;

   function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
      return (&v) ? v : v + CNTW'(1);
   endfunction

   assign md_in   = VEC_MSG[32'(idx_q)*ILEN +: ILEN];
   assign exp_md  = VEC_MD[32'(idx_q)*MDLEN +: MDLEN];
   assign at_last = (idx_q == LAST_IDX);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      rcnt_d  = rcnt_q;
      wdog_d  = wdog_q;
      end_d   = end_q;
      dig_d   = dig_q;
      led_d   = led_q;
      pass_d  = pass_q;
      fail_d  = fail_q;
      tmo_d   = tmo_q;
      lfi_d   = lfi_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_CRST;
               idx_d   = '0;
               rcnt_d  = '0;
               end_d   = 1'b0;
               pass_d  = '0;
               fail_d  = '0;
               tmo_d   = '0;
               lfi_d   = '0;
            end
         end
         S_CRST: begin
            // end_q marks a timeout on the final vector of a single pass
            if (rcnt_q == RCW'(RSTCYC - 1)) begin
               state_d = end_q ? S_DONE : S_REQ;
            end else begin
               rcnt_d = rcnt_q + RCW'(1);
            end
         end
         S_REQ: begin
            if (req_valid_q && req_ready) begin
               state_d = S_WAIT;
               wdog_d  = '0;
            end
         end
         S_WAIT: begin
            if (res_valid && res_ready_q) begin
               dig_d   = md_out;
               led_d   = ~md_out[MDLEN-1 -: 8];
               state_d = S_CHECK;
            end else if (wdog_q == WDW'(TIMEOUT)) begin
               fail_d  = sat_inc(fail_q);
               tmo_d   = sat_inc(tmo_q);
               lfi_d   = idx_q;
               rcnt_d  = '0;
               state_d = S_CRST;
               if (!at_last) begin
                  idx_d = idx_q + 4'd1;
               end else if (continuous) begin
                  idx_d = '0;
               end else begin
                  end_d = 1'b1;
               end
            end else begin
               wdog_d = wdog_q + WDW'(1);
            end
         end
         S_CHECK: begin
            if (dig_q == exp_md) begin
               pass_d = sat_inc(pass_q);
            end else begin
               fail_d = sat_inc(fail_q);
               lfi_d  = idx_q;
            end
            if (!at_last) begin
               idx_d   = idx_q + 4'd1;
               state_d = S_REQ;
            end else if (continuous) begin
               idx_d   = '0;
               state_d = S_REQ;
            end else begin
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         rcnt_q      <= '0;
         wdog_q      <= '0;
         end_q       <= 1'b0;
         dig_q       <= '0;
         led_q       <= 8'hFF;
         pass_q      <= '0;
         fail_q      <= '0;
         tmo_q       <= '0;
         lfi_q       <= '0;
         core_rst_q  <= 1'b1;
         req_valid_q <= 1'b0;
         res_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         rcnt_q      <= rcnt_d;
         wdog_q      <= wdog_d;
         end_q       <= end_d;
         dig_q       <= dig_d;
         led_q       <= led_d;
         pass_q      <= pass_d;
         fail_q      <= fail_d;
         tmo_q       <= tmo_d;
         lfi_q       <= lfi_d;
         // handshake and status outputs are registered from the next state
         core_rst_q  <= (state_d == S_IDLE) || (state_d == S_CRST);
         req_valid_q <= (state_d == S_REQ);
         res_ready_q <= (state_d == S_WAIT);
         busy_q      <= (state_d != S_IDLE) && (state_d != S_DONE);
         done_q      <= (state_d == S_DONE);
      end
   end

   assign core_rst      = core_rst_q;
   assign req_valid     = req_valid_q;
   assign res_ready     = res_ready_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign pass_cnt      = pass_q;
   assign fail_cnt      = fail_q;
   assign timeout_cnt   = tmo_q;
   assign last_fail_idx = lfi_q;
   assign led           = led_q;

endmodule

// File: tb/tb_sha3_selftest.sv
// Bench for sha3_selftest: a 4-vector instance with a scripted core model and a 1-vector fox instance with a 4-bit counter.
module tb_sha3_selftest;

   localparam int ILEN  = 344;
   localparam int MDLEN = 256;
   localparam int NV    = 4;

   localparam logic [NV*ILEN-1:0] M_MSG = {344'h4444_abcd, 344'h3333_abcd,
                                           344'h2222_abcd, 344'h1111_abcd};
   localparam logic [NV*MDLEN-1:0] M_MD = {{8'hD3, 248'h3}, {8'hC2, 248'h2},
                                           {8'hB1, 248'h1}, {8'hA0, 248'h0}};
   localparam logic [ILEN-1:0]  FOX_MSG = "The quick brown fox jumps over the lazy dog";
   localparam logic [MDLEN-1:0] FOX_MD  =
      256'h69070dda01975c8c120c3aada1b282394e7f032fa9cf32f4cb2259a0897dfc04;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   logic             m_start, m_cont, m_core_rst, m_req_valid, m_req_ready;
   logic             m_res_valid, m_res_ready, m_busy, m_done;
   logic [ILEN-1:0]  m_md_in;
   logic [MDLEN-1:0] m_md_out;
   logic [15:0]      m_pass, m_fail, m_tmo;
   logic [3:0]       m_lfi;
   logic [7:0]       m_led;

   logic             s_start, s_cont, s_core_rst, s_req_valid, s_req_ready;
   logic             s_res_valid, s_res_ready, s_busy, s_done;
   logic [ILEN-1:0]  s_md_in;
   logic [MDLEN-1:0] s_md_out;
   logic [3:0]       s_pass, s_fail, s_tmo;
   logic [3:0]       s_lfi;
   logic [7:0]       s_led;

   sha3_selftest #(.MDLEN(MDLEN), .ILEN(ILEN), .NVEC(NV), .VEC_MSG(M_MSG), .VEC_MD(M_MD),
                   .RSTCYC(4), .TIMEOUT(15), .CNTW(16)) u_main (
      .clk(clk), .rstn(rstn), .start(m_start), .continuous(m_cont),
      .core_rst(m_core_rst), .md_in(m_md_in), .req_valid(m_req_valid), .req_ready(m_req_ready),
      .res_valid(m_res_valid), .res_ready(m_res_ready), .md_out(m_md_out),
      .busy(m_busy), .done(m_done), .pass_cnt(m_pass), .fail_cnt(m_fail),
      .timeout_cnt(m_tmo), .last_fail_idx(m_lfi), .led(m_led));

   sha3_selftest #(.MDLEN(MDLEN), .ILEN(ILEN), .NVEC(1), .VEC_MSG(FOX_MSG), .VEC_MD(FOX_MD),
                   .RSTCYC(4), .TIMEOUT(4095), .CNTW(4)) u_fox (
      .clk(clk), .rstn(rstn), .start(s_start), .continuous(s_cont),
      .core_rst(s_core_rst), .md_in(s_md_in), .req_valid(s_req_valid), .req_ready(s_req_ready),
      .res_valid(s_res_valid), .res_ready(s_res_ready), .md_out(s_md_out),
      .busy(s_busy), .done(s_done), .pass_cnt(s_pass), .fail_cnt(s_fail),
      .timeout_cnt(s_tmo), .last_fail_idx(s_lfi), .led(s_led));

   // Scripted core for the 4-vector instance.
   int   mdl_corrupt = -1;
   int   mdl_hang    = -1;
   int   mdl_lat     = 3;
   int   acc [NV];
   logic m_pend;
   int   m_cnt, m_pidx;

   function automatic int lookup(input logic [ILEN-1:0] m);
      for (int i = 0; i < NV; i++) if (m == M_MSG[i*ILEN +: ILEN]) return i;
      return -1;
   endfunction

   function automatic logic [MDLEN-1:0] mdig(input int i);
      if (i < 0 || i >= NV) return '0;
      return M_MD[i*MDLEN +: MDLEN];
   endfunction

   function automatic logic [ILEN-1:0] mmsg(input int i);
      return M_MSG[i*ILEN +: ILEN];
   endfunction

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_pend <= 1'b0; m_res_valid <= 1'b0; m_md_out <= '0; m_cnt <= 0; m_pidx <= 0;
      end else if (m_core_rst) begin
         m_pend <= 1'b0; m_res_valid <= 1'b0;
      end else if (m_req_valid && m_req_ready) begin
         m_pend <= 1'b1;
         m_cnt  <= mdl_lat;
         m_pidx <= lookup(m_md_in);
         if (lookup(m_md_in) >= 0) acc[lookup(m_md_in)] <= acc[lookup(m_md_in)] + 1;
      end else if (m_res_valid) begin
         if (m_res_ready) begin
            m_res_valid <= 1'b0; m_pend <= 1'b0;
         end
      end else if (m_pend && m_pidx != mdl_hang) begin
         if (m_cnt == 0) begin
            m_res_valid <= 1'b1;
            m_md_out    <= mdig(m_pidx) ^ MDLEN'(m_pidx == mdl_corrupt);
         end else begin
            m_cnt <= m_cnt - 1;
         end
      end
   end

   // Fox core: 24-cycle latency, correct digest only for the fox message.
   logic s_pend;
   int   s_cnt;
   int   s_resp = 0;
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s_pend <= 1'b0; s_res_valid <= 1'b0; s_md_out <= '0; s_cnt <= 0;
      end else if (s_core_rst) begin
         s_pend <= 1'b0; s_res_valid <= 1'b0;
      end else if (s_req_valid && s_req_ready) begin
         s_pend <= 1'b1; s_cnt <= 24;
      end else if (s_res_valid) begin
         if (s_res_ready) begin
            s_res_valid <= 1'b0; s_pend <= 1'b0; s_resp <= s_resp + 1;
         end
      end else if (s_pend) begin
         if (s_cnt == 0) begin
            s_res_valid <= 1'b1;
            s_md_out    <= (s_md_in == FOX_MSG) ? FOX_MD : '0;
         end else begin
            s_cnt <= s_cnt - 1;
         end
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic pulse_m_start();
      m_start = 1'b1;
      @(negedge clk);
      m_start = 1'b0;
   endtask

   task automatic wait_m_done(input string nm);
      int n = 0;
      while (m_done !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
      chk({nm, "_reach_done"}, 64'(m_done === 1'b1), 64'd1);
   endtask

   task automatic wait_s_done(input string nm);
      int n = 0;
      while (s_done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
      chk({nm, "_reach_done"}, 64'(s_done === 1'b1), 64'd1);
   endtask

   typedef struct {
      int         corrupt;
      int         hang;
      int         lat;
      int         e_pass;
      int         e_fail;
      int         e_tmo;
      int         e_lfi;
      logic [7:0] e_led;
   } vec_t;

   vec_t tbl [4];
   int   acc0 [NV];

   initial begin
      #200000;
      $display("FAIL global_time_limit: simulation did not finish");
      $fatal(1, "time limit");
   end

   initial begin
      int n, ok;
      tbl[0] = '{corrupt: 2,  hang: -1, lat: 3, e_pass: 3, e_fail: 1, e_tmo: 0, e_lfi: 2,  e_led: 8'h2C};
      tbl[1] = '{corrupt: -1, hang: -1, lat: 0, e_pass: 4, e_fail: 0, e_tmo: 0, e_lfi: -1, e_led: 8'h2C};
      tbl[2] = '{corrupt: 0,  hang: -1, lat: 5, e_pass: 3, e_fail: 1, e_tmo: 0, e_lfi: 0,  e_led: 8'h2C};
      tbl[3] = '{corrupt: -1, hang: 3,  lat: 1, e_pass: 3, e_fail: 1, e_tmo: 1, e_lfi: 3,  e_led: 8'h3D};

      m_start = 1'b0; m_cont = 1'b0; m_req_ready = 1'b1;
      s_start = 1'b0; s_cont = 1'b0; s_req_ready = 1'b1;
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_core_rst", 64'(m_core_rst), 64'd1);
      chk("rst_req_valid", 64'(m_req_valid), 64'd0);
      chk("rst_res_ready", 64'(m_res_ready), 64'd0);
      chk("rst_counters", 64'({m_pass, m_fail, m_tmo}), 64'd0);
      chk("rst_lfi", 64'(m_lfi), 64'd0);
      chk("rst_led", 64'(m_led), 64'hFF);
      chk("rst_busy_done", 64'({m_busy, m_done}), 64'd0);
      rstn = 1'b1;
      @(negedge clk);
      chk("idle_core_rst", 64'(m_core_rst), 64'd1);

      // start latency plus req_ready back-pressure on vector 0
      m_req_ready = 1'b0;
      m_start = 1'b1;
      @(negedge clk);
      m_start = 1'b0;
      n = 1;
      chk("crst_core_rst", 64'(m_core_rst), 64'd1);
      while (m_req_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      chk("start_to_req_cycles", 64'(n), 64'd5);
      chk("req_core_rst_low", 64'(m_core_rst), 64'd0);
      for (int i = 0; i < NV; i++) acc0[i] = acc[i];
      ok = 1;
      for (int k = 0; k < 5; k++) begin
         if (m_req_valid !== 1'b1 || m_md_in !== mmsg(0)) ok = 0;
         @(negedge clk);
      end
      chk("bp_req_held_md_stable", 64'(ok), 64'd1);
      m_req_ready = 1'b1;
      @(negedge clk);
      chk("req_valid_drops", 64'(m_req_valid), 64'd0);
      chk("res_ready_in_wait", 64'(m_res_ready), 64'd1);
      wait_m_done("bp");
      chk("bp_pass", 64'(m_pass), 64'd4);
      ok = 1;
      for (int i = 0; i < NV; i++) if (acc[i] - acc0[i] != 1) ok = 0;
      chk("bp_one_req_per_vec", 64'(ok), 64'd1);

      for (int r = 0; r < 4; r++) begin
         mdl_corrupt = tbl[r].corrupt;
         mdl_hang    = tbl[r].hang;
         mdl_lat     = tbl[r].lat;
         for (int i = 0; i < NV; i++) acc0[i] = acc[i];
         pulse_m_start();
         wait_m_done($sformatf("row%0d", r));
         chk($sformatf("row%0d_pass", r), 64'(m_pass), 64'(tbl[r].e_pass));
         chk($sformatf("row%0d_fail", r), 64'(m_fail), 64'(tbl[r].e_fail));
         chk($sformatf("row%0d_tmo", r), 64'(m_tmo), 64'(tbl[r].e_tmo));
         if (tbl[r].e_lfi >= 0) chk($sformatf("row%0d_lfi", r), 64'(m_lfi), 64'(tbl[r].e_lfi));
         chk($sformatf("row%0d_led", r), 64'(m_led), 64'(tbl[r].e_led));
         ok = 1;
         for (int i = 0; i < NV; i++) if (acc[i] - acc0[i] != 1) ok = 0;
         chk($sformatf("row%0d_one_req_per_vec", r), 64'(ok), 64'd1);
      end

      // watchdog timing on vector 1
      mdl_corrupt = -1; mdl_hang = 1; mdl_lat = 2;
      pulse_m_start();
      n = 0;
      while (!(m_res_ready === 1'b1 && m_md_in == mmsg(1)) && n < 200) begin @(negedge clk); n++; end
      chk("tmo_reach_wait1", 64'(m_res_ready === 1'b1), 64'd1);
      n = 0;
      while (m_res_ready === 1'b1 && n < 100) begin n++; @(negedge clk); end
      chk("tmo_wait_cycles", 64'(n), 64'd16);
      chk("tmo_core_rst", 64'(m_core_rst), 64'd1);
      chk("tmo_idx_advanced", 64'(m_md_in == mmsg(2)), 64'd1);
      n = 0;
      while (m_core_rst === 1'b1 && n < 50) begin n++; @(negedge clk); end
      chk("tmo_core_rst_cycles", 64'(n), 64'd4);
      chk("tmo_resume_req", 64'(m_req_valid), 64'd1);
      wait_m_done("tmo");
      chk("tmo_counts", 64'({m_pass, m_fail, m_tmo}), 64'({16'd3, 16'd1, 16'd1}));
      chk("tmo_lfi", 64'(m_lfi), 64'd1);

      // restart from DONE clears counters
      mdl_hang = -1;
      pulse_m_start();
      chk("restart_cleared", 64'({m_fail, m_tmo}), 64'd0);
      chk("restart_busy", 64'({m_busy, m_done}), 64'b10);
      wait_m_done("restart");
      chk("restart_pass", 64'(m_pass), 64'd4);

      // start ignored while busy, then async reset in WAIT
      mdl_hang = 2;
      pulse_m_start();
      n = 0;
      while (!(m_res_ready === 1'b1 && m_md_in == mmsg(2)) && n < 200) begin @(negedge clk); n++; end
      chk("arst_pass_before", 64'(m_pass), 64'd2);
      pulse_m_start();
      @(negedge clk);
      chk("busy_start_ignored", 64'({m_busy, m_res_ready, m_pass}), 64'({1'b1, 1'b1, 16'd2}));
      #2 rstn = 1'b0;
      #1;
      chk("arst_core_rst", 64'(m_core_rst), 64'd1);
      chk("arst_outputs", 64'({m_res_ready, m_req_valid, m_busy, m_done}), 64'd0);
      chk("arst_counters", 64'(m_pass), 64'd0);
      @(negedge clk);
      rstn = 1'b1;
      mdl_hang = -1;
      mdl_lat  = 0;
      @(negedge clk);

      // continuous: 3 passes, drop mid-pass 4
      m_cont = 1'b1;
      pulse_m_start();
      n = 0;
      while (m_pass < 16'd12 && n < 2000) begin @(negedge clk); n++; end
      chk("cont_still_running", 64'({m_pass, m_done}), 64'({16'd12, 1'b0}));
      n = 0;
      while (m_md_in != mmsg(1) && n < 100) begin @(negedge clk); n++; end
      m_cont = 1'b0;
      wait_m_done("cont");
      chk("cont_pass", 64'(m_pass), 64'd16);
      chk("cont_fail", 64'(m_fail), 64'd0);

      // fox vector single pass, then 4-bit saturation in continuous mode
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      wait_s_done("fox");
      chk("fox_pass_fail", 64'({s_pass, s_fail}), 64'({4'd1, 4'd0}));
      chk("fox_led", 64'(s_led), 64'h96);
      s_cont = 1'b1;
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      n = s_resp;
      ok = 0;
      while (s_resp < n + 18 && ok < 2500) begin @(negedge clk); ok++; end
      chk("sat_reach_18", 64'(s_resp >= n + 18), 64'd1);
      s_cont = 1'b0;
      wait_s_done("sat");
      chk("sat_pass", 64'(s_pass), 64'd15);
      chk("sat_fail", 64'(s_fail), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sha3_selftest.md
# sha3_selftest

Parametrised built-in self-test sequencer for the `sha3` core. It drives the core through a set of NVEC compile-time test vectors using the core's req/res handshake, compares each digest against its expected value, and keeps pass, fail and timeout counters. It supports single-pass and continuous modes and recovers from a hung core with a watchdog. It sits between the board top (PLL clock, button, LEDs) and one `sha3` instance.

## Interface
- MDLEN, 256, digest width in bits
- ILEN, 344, message width in bits
- NVEC, 4, number of test vectors (1..16)
- VEC_MSG, 0, NVEC*ILEN flat message ROM; vector i is at [i*ILEN +: ILEN]
- VEC_MD, 0, NVEC*MDLEN flat expected-digest ROM; vector i is at [i*MDLEN +: MDLEN]
- RSTCYC, 4, number of cycles core_rst is held
- TIMEOUT, 4095, maximum WAIT cycles before a watchdog abort
- CNTW, 16, width of each counter

Ports:
- clk  in  1  system clock (PLL output)
- rstn  in  1  **asynchronous, active-low reset**
- start  in  1  level; sampled in IDLE or DONE
- continuous  in  1  level; 1 = loop over the vectors forever
- core_rst  out  1  reset to the sha3 core
- md_in  out  ILEN  current message
- req_valid  out  1  request valid
- req_ready  in  1  core accepts the request
- res_valid  in  1  digest valid
- res_ready  out  1  digest accepted
- md_out  in  MDLEN  core digest
- busy  out  1  state is neither IDLE nor DONE
- done  out  1  state is DONE
- pass_cnt, fail_cnt, timeout_cnt  out  CNTW  saturating counters
- last_fail_idx  out  4  index of the most recent failing vector
- led  out  8  ~captured_digest[MDLEN-1 -: 8] (LEDs are active-low)

## Operation
- States: IDLE, CRST, REQ, WAIT, CHECK, DONE.
- IDLE: on start=1, clear all counters and set idx=0, then go to CRST.
- CRST: hold core_rst=1 for RSTCYC cycles, then go to REQ.
- REQ: req_valid=1 and md_in=VEC_MSG[idx].
  - md_in shows the current vector in every state.
  - On req_valid&&req_ready, go to WAIT.
- WAIT: res_ready=1 and the watchdog counts up from 0.
  - On res_valid&&res_ready: capture md_out and go to CHECK.
  - If the watchdog reaches TIMEOUT before that: fail_cnt+1, timeout_cnt+1, last_fail_idx=idx, advance idx, go to CRST.
- CHECK (one cycle): compare the captured digest with VEC_MD[idx].
  - Match: pass_cnt+1.
  - Mismatch: fail_cnt+1 and last_fail_idx=idx.
  - Then advance idx.
- idx advance rules:
  - idx<NVEC-1: idx+1, go to REQ.
  - idx==NVEC-1 with continuous=1: idx=0, go to REQ.
  - idx==NVEC-1 with continuous=0: go to DONE.
  - After a timeout the next state is always CRST. The same continuous rule decides whether the sequence then resumes or ends in DONE.
- DONE: outputs and counters hold. start=1 restarts the sequence as from IDLE.
- start is ignored while busy. Dropping continuous takes effect at the next end of a pass.
- Counters saturate at 2^CNTW-1 and do not wrap.
- led updates only on digest capture.
- res_valid seen outside WAIT is ignored (res_ready=0).

## Timing
- Reset values: state=IDLE, core_rst=1, req_valid=0, res_ready=0, all counters 0, last_fail_idx=0, led=8'hFF, busy=0, done=0.
- Asserting rstn low mid-sequence returns to IDLE immediately, with core_rst=1. core_rst stays 1 in IDLE.
- From start high to the first req_valid: 1 (IDLE→CRST) + RSTCYC cycles.
- req_valid drops the cycle after the handshake.
- res_ready is registered: it is high from the first WAIT cycle and low in CHECK.
- A counter update is visible 1 cycle after CHECK is entered.
- Minimum per-vector cost with an ideal core: REQ(1) + WAIT(≥1) + CHECK(1) = 3 cycles.
- Timeout fires on WAIT cycle TIMEOUT+1. Watchdog width is clog2(TIMEOUT+1).
- All outputs are registered except md_in, which is a ROM mux on idx.

## Test plan
- Single pass, NVEC=1, fox vector with expected digest 69070dda…897dfc04, model core returns the correct digest after 24 cycles → pass_cnt=1, fail_cnt=0, done=1, led=~8'h69=8'h96.
- NVEC=4, model corrupts vector 2's digest (bit 0 flipped) → pass_cnt=3, fail_cnt=1, last_fail_idx=2, timeout_cnt=0.
- Model never raises res_valid on vector 1, TIMEOUT=15 → timeout fires on WAIT cycle 16, followed by core_rst held 4 cycles, then vectors 2 and 3 are processed; final counts pass=3, fail=1, timeout=1.
- continuous=1 for 3 full passes, then dropped mid-pass → ends in DONE after finishing that pass; pass_cnt=16 for NVEC=4. With CNTW=4 the counter saturates at 15.
- rstn pulsed low while in WAIT → asynchronously returns to IDLE with counters 0 and core_rst=1; start is ignored while busy; start in DONE restarts with counters cleared.
- Back-pressure: req_ready low for 5 cycles → req_valid held with md_in stable, and exactly one request is accepted per vector.
